// File: rtl/dist_pkg.sv
// dist_pkg: shared types, FSM encoding and accumulator sizing for the matrix distance engine
package dist_pkg;
    localparam int CPLX_W = 19;
    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} dist_state_e;
    function automatic int dist_acc_w(input int n, input int width);
        return 2 * width + $clog2(2 * n * n);
    endfunction
endpackage

// File: rtl/cplx_sqdiff.sv
// cplx_sqdiff: two-stage registered squared magnitude of one complex difference
module cplx_sqdiff
    import dist_pkg::*;
#(
    parameter int WIDTH = CPLX_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    input  logic signed [WIDTH-1:0] a_re,
    input  logic signed [WIDTH-1:0] a_im,
    input  logic signed [WIDTH-1:0] b_re,
    input  logic signed [WIDTH-1:0] b_im,
    output logic                    valid_out,
    output logic [2*WIDTH:0]        sq
);
    logic signed [WIDTH:0]   dre, dim;
    logic signed [2*WIDTH:0] xre, xim;
    logic                    valid_d;
    // |diff| <= 2^WIDTH-1, so the sum of squares fits 2*WIDTH+1 bits; modular math stays exact
    always_comb begin
        xre = (2*WIDTH+1)'(dre);
        xim = (2*WIDTH+1)'(dim);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            dre       <= '0;
            dim       <= '0;
            valid_d   <= 1'b0;
            valid_out <= 1'b0;
            sq        <= '0;
        end else begin
            valid_d   <= valid_in;
            valid_out <= valid_d;
            dre       <= (WIDTH+1)'(a_re) - (WIDTH+1)'(b_re);
            dim       <= (WIDTH+1)'(a_im) - (WIDTH+1)'(b_im);
            sq        <= xre * xre + xim * xim;
        end
    end
endmodule

// File: rtl/mtx_dist_seq.sv
// mtx_dist_seq: sequential N x N complex squared-distance engine; DIST_MIN_TRACK_EN adds best-result tracking
module mtx_dist_seq
    import dist_pkg::*;
#(
    parameter int N         = 2,
    parameter int WIDTH     = CPLX_W,
    parameter int RUN_CNT_W = 16,
    localparam int ACC_W    = dist_acc_w(N, WIDTH)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [N-1:0][N-1:0][1:0][WIDTH-1:0] mtx_a,
    input  logic [N-1:0][N-1:0][1:0][WIDTH-1:0] mtx_b,
    input  logic                                 ready,
    output logic                                 busy,
    output logic [ACC_W-1:0]                     dist2,
    output logic                                 finished
`ifdef DIST_MIN_TRACK_EN
    ,
    output logic [ACC_W-1:0]                     best_dist2,
    output logic [RUN_CNT_W-1:0]                 best_idx,
    output logic                                 new_best
`endif
);
    localparam int IDX_W = N > 1 ? $clog2(N * N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N * N - 1);
    dist_state_e                     state;
    logic [N*N-1:0][1:0][WIDTH-1:0] a_r, b_r;
    logic [IDX_W-1:0]                idx;
    logic                            drain_last;
    logic [ACC_W-1:0]                acc;
    logic                            sq_valid;
    logic [2*WIDTH:0]                sq;
    // flattened latches put element (row, col) at index row*N+col
    cplx_sqdiff #(.WIDTH(WIDTH)) u_sqdiff (
        .clk      (clk),
        .reset    (reset),
        .valid_in (state == RUN),
        .a_re     ($signed(a_r[idx][0])),
        .a_im     ($signed(a_r[idx][1])),
        .b_re     ($signed(b_r[idx][0])),
        .b_im     ($signed(b_r[idx][1])),
        .valid_out(sq_valid),
        .sq       (sq)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            a_r        <= '0;
            b_r        <= '0;
            idx        <= '0;
            drain_last <= 1'b0;
            acc        <= '0;
            busy       <= 1'b0;
            finished   <= 1'b0;
            dist2      <= '0;
        end else begin
            finished <= 1'b0;
            if (sq_valid) acc <= acc + ACC_W'(sq);
            case (state)
                IDLE: if (ready) begin
                    a_r   <= mtx_a;
                    b_r   <= mtx_b;
                    acc   <= '0;
                    idx   <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    idx        <= idx + IDX_W'(1);
                    drain_last <= 1'b0;
                    if (idx == LAST) state <= DRAIN;
                end
                DRAIN: begin
                    drain_last <= 1'b1;
                    if (drain_last) state <= DONE;
                end
                DONE: begin
                    dist2    <= acc;
                    finished <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
`ifdef DIST_MIN_TRACK_EN
    logic [RUN_CNT_W-1:0] run_cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            best_dist2 <= '1;
            best_idx   <= '0;
            run_cnt    <= '0;
            new_best   <= 1'b0;
        end else begin
            new_best <= state == DONE && acc < best_dist2;
            if (state == DONE) begin
                run_cnt <= run_cnt + RUN_CNT_W'(1);
                if (acc < best_dist2) begin
                    best_dist2 <= acc;
                    best_idx   <= run_cnt;
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_mtx_dist_seq.sv
// tb_mtx_dist_seq: randomized scoreboard bench for mtx_dist_seq against a plain-arithmetic distance model
module tb_mtx_dist_seq;
    localparam int N     = 2;
    localparam int W     = 19;
    localparam int ACC_W = 2 * W + $clog2(2 * N * N);
    typedef logic [N-1:0][N-1:0][1:0][W-1:0] mtx_t;
    typedef struct {
        longint val;
        int     cyc;
    } exp_t;

    logic clk = 1'b0, reset = 1'b1, ready = 1'b0;
    mtx_t mtx_a = '0, mtx_b = '0;
    logic busy, finished;
    logic [ACC_W-1:0] dist2;
    exp_t q[$];
    exp_t e_m;
    int total = 0, bad = 0, cyc = 0, busy_len = 0;
`ifdef DIST_MIN_TRACK_EN
    logic [ACC_W-1:0] best_dist2;
    logic [15:0]      best_idx;
    logic             new_best;
    longint best_m = (longint'(1) << ACC_W) - 1;
    int run_m = 0, idx_m = 0, nb_cnt = 0;
    logic exp_nb;
`endif

    mtx_dist_seq dut (
        .clk       (clk),
        .reset     (reset),
        .mtx_a     (mtx_a),
        .mtx_b     (mtx_b),
        .ready     (ready),
        .busy      (busy),
        .dist2     (dist2),
        .finished  (finished)
`ifdef DIST_MIN_TRACK_EN
        ,
        .best_dist2(best_dist2),
        .best_idx  (best_idx),
        .new_best  (new_best)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic longint model(input mtx_t a, input mtx_t b);
        longint s = 0;
        longint d;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                for (int k = 0; k < 2; k++) begin
                    d = longint'($signed(a[r][c][k])) - longint'($signed(b[r][c][k]));
                    s += d * d;
                end
        return s;
    endfunction

    function automatic mtx_t rnd_mtx();
        mtx_t m;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                for (int k = 0; k < 2; k++) m[r][c][k] = W'($urandom);
        return m;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            busy_len = 0;
`ifdef DIST_MIN_TRACK_EN
            best_m = (longint'(1) << ACC_W) - 1;
            run_m  = 0;
            idx_m  = 0;
`endif
        end else begin
            if (busy) busy_len++;
            if (finished) begin
                chk("finish_expected", longint'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e_m = q.pop_front();
                    chk("dist2", longint'(dist2), e_m.val);
                    chk("finish_cycle", cyc, e_m.cyc);
                    chk("busy_len", busy_len, N * N + 3);
                    chk("busy_at_done", longint'(busy), 0);
`ifdef DIST_MIN_TRACK_EN
                    exp_nb = e_m.val < best_m;
                    chk("new_best", longint'(new_best), longint'(exp_nb));
                    if (exp_nb) begin
                        best_m = e_m.val;
                        idx_m  = run_m;
                    end
                    run_m++;
                    chk("best_dist2", longint'(best_dist2), best_m);
                    chk("best_idx", longint'(best_idx), idx_m);
`endif
                end
                busy_len = 0;
            end
`ifdef DIST_MIN_TRACK_EN
            if (new_best) nb_cnt++;
            if (!finished) chk("new_best_idle", longint'(new_best), 0);
`endif
        end
    end

    task automatic run1(input mtx_t a, input mtx_t b);
        mtx_a = a;
        mtx_b = b;
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        chk("busy_accept", longint'(busy), 1);
        q.push_back(exp_t'{model(a, b), cyc + N * N + 3});
        mtx_a = rnd_mtx();
        mtx_b = rnd_mtx();
        repeat (N * N + 4) @(posedge clk);
        #1;
    endtask

    initial begin
        mtx_t zero, ramp, p34, neg, pos, ra;
        mtx_t seq_a[3], seq_b[3];
        int c0;
        zero = '0;
        ramp = '0;
        ramp[0][0][0] = 1;
        ramp[0][1][0] = 2;
        ramp[1][0][0] = 3;
        ramp[1][1][0] = 4;
        p34 = '0;
        p34[0][0][0] = 3;
        p34[0][0][1] = 4;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                for (int k = 0; k < 2; k++) begin
                    neg[r][c][k] = W'(1 << (W - 1));
                    pos[r][c][k] = W'((1 << (W - 1)) - 1);
                end
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", longint'(busy), 0);
        chk("reset_finished", longint'(finished), 0);
        chk("reset_dist2", longint'(dist2), 0);
`ifdef DIST_MIN_TRACK_EN
        chk("reset_best", longint'(best_dist2), (longint'(1) << ACC_W) - 1);
        chk("reset_best_idx", longint'(best_idx), 0);
`endif
        reset = 1'b0;
        @(posedge clk);
        #1;
        seq_a = '{ramp, zero, ramp};
        seq_b = '{zero, p34, zero};
        ready = 1'b1;
        c0 = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            mtx_a = seq_a[k];
            mtx_b = seq_b[k];
            @(posedge clk);
            #1;
            chk("busy_b2b", longint'(busy), 1);
            q.push_back(exp_t'{model(seq_a[k], seq_b[k]), c0 + 8 * k + N * N + 3});
            repeat (3) @(posedge clk);
            #1;
            mtx_a = rnd_mtx();
            mtx_b = rnd_mtx();
            repeat (4) @(posedge clk);
            #1;
        end
        ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`ifdef DIST_MIN_TRACK_EN
        chk("b2b_best", longint'(best_dist2), 25);
        chk("b2b_best_idx", longint'(best_idx), 1);
        chk("b2b_new_best_cnt", nb_cnt, 2);
`endif
        ra = rnd_mtx();
        run1(ra, ra);
        run1(p34, zero);
        run1(neg, pos);
        run1(pos, neg);
        for (int i = 0; i < 6; i++) run1(rnd_mtx(), rnd_mtx());
        mtx_a = rnd_mtx();
        mtx_b = rnd_mtx();
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", longint'(busy), 0);
        chk("abort_dist2", longint'(dist2), 0);
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_idle_busy", longint'(busy), 0);
        run1(rnd_mtx(), rnd_mtx());
        run1(ramp, zero);
        repeat (4) @(posedge clk);
        #1;
        chk("pending", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
